// File: rtl/switch_debounce_reader_if.sv
// Event channel from the switch debouncer to its consumer: a new debounced value
// plus the mask of bits that changed, moved with a valid/ready handshake.
interface switch_debounce_reader_if #(
  parameter int WIDTH = 8
);
  logic             event_valid;
  logic             event_ready;
  logic [WIDTH-1:0] event_data;
  logic [WIDTH-1:0] event_mask;

  modport master (
    output event_valid,
    output event_data,
    output event_mask,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_data,
    input  event_mask,
    output event_ready
  );
endinterface

// File: rtl/switch_debounce_reader.sv
// Synchronizes and debounces the switch bank as a whole vector, drives the LEDs
// from the debounced state and reports every debounced change as a handshaked event.
module switch_debounce_reader #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         switch,
  output logic [WIDTH-1:0]         led,
  output logic                     overrun,
  switch_debounce_reader_if.master ev
);

  localparam logic [15:0] CNT_LAST = 16'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_sw_s1;
  logic [WIDTH-1:0] r_sw_s2;
  logic [WIDTH-1:0] r_cand;
  logic [15:0]      r_cnt;
  logic [WIDTH-1:0] r_led;
  logic             r_ev_valid;
  logic [WIDTH-1:0] r_ev_data;
  logic [WIDTH-1:0] r_ev_mask;
  logic             r_overrun;

  logic             w_stable;
  logic             w_change;
  logic [WIDTH-1:0] w_diff;

  assign w_stable = (r_sw_s2 == r_cand);
  assign w_change = w_stable && (r_cnt == CNT_LAST) && (r_cand != r_led);
  assign w_diff   = r_led ^ r_cand;

  // Plain two-flop synchronizer; nothing may sit between the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= switch;
      r_sw_s2 <= r_sw_s1;
    end
  end

  // Any movement of the synchronized vector restarts the qualification count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand <= '0;
      r_cnt  <= '0;
      r_led  <= '0;
    end else if (!w_stable) begin
      r_cand <= r_sw_s2;
      r_cnt  <= '0;
    end else if (w_change) begin
      r_led <= r_cand;
    end else if (r_cnt < CNT_LAST) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // A change landing on an unaccepted event merges into it and flags overrun;
  // an accept on the same edge as a change starts a fresh mask instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ev_valid <= 1'b0;
      r_ev_data  <= '0;
      r_ev_mask  <= '0;
      r_overrun  <= 1'b0;
    end else if (w_change) begin
      r_ev_valid <= 1'b1;
      r_ev_data  <= r_cand;
      if (!r_ev_valid || ev.event_ready) begin
        r_ev_mask <= w_diff;
      end else begin
        r_ev_mask <= r_ev_mask | w_diff;
        r_overrun <= 1'b1;
      end
    end else if (r_ev_valid && ev.event_ready) begin
      r_ev_valid <= 1'b0;
    end
  end

  assign led            = r_led;
  assign overrun        = r_overrun;
  assign ev.event_valid = r_ev_valid;
  assign ev.event_data  = r_ev_data;
  assign ev.event_mask  = r_ev_mask;

endmodule

// File: tb/tb_switch_debounce_reader.sv
// Directed table plus hand-written corner sequences and a random soak with an
// event-level scoreboard for switch_debounce_reader.
module tb_switch_debounce_reader;

  localparam int WIDTH = 8;
  localparam int STABLE_CYCLES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] led;
  logic             overrun;

  switch_debounce_reader_if #(.WIDTH(WIDTH)) ev_if ();

  switch_debounce_reader #(
    .WIDTH(WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .switch (sw),
    .led    (led),
    .overrun(overrun),
    .ev     (ev_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sw;
    logic       rdy;
    int         cycles;
    logic [7:0] led;
    logic       valid;
    logic [7:0] data;
    logic [7:0] mask;
    logic       ovr;
  } vec_t;

  vec_t vecs[7];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model state for the soak.
  logic [7:0] m_led, m_data, m_mask;
  logic       m_valid, m_ovr;

  initial begin
    vecs[0] = '{8'h00, 1'b0, 10, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1,  8'h00, 1'b0, 8'h00, 8'hFF, 1'b0};
    vecs[2] = '{8'hCD, 1'b0, 10, 8'hCD, 1'b1, 8'hCD, 8'hCD, 1'b0};
    vecs[3] = '{8'h0F, 1'b0, 10, 8'h0F, 1'b1, 8'h0F, 8'hCF, 1'b1};
    vecs[4] = '{8'h0F, 1'b1, 1,  8'h0F, 1'b0, 8'h0F, 8'hCF, 1'b1};
    vecs[5] = '{8'h0F, 1'b1, 5,  8'h0F, 1'b0, 8'h0F, 8'hCF, 1'b1};
    vecs[6] = '{8'h30, 1'b1, 10, 8'h30, 1'b0, 8'h30, 8'h3F, 1'b1};

    rst = 1'b1;
    sw = 8'h00;
    ev_if.event_ready = 1'b0;
    #3;
    chk("reset_led", 32'(led), 32'h00);
    chk("reset_valid", 32'(ev_if.event_valid), 32'h0);
    chk("reset_ovr", 32'(overrun), 32'h0);
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_valid", 32'(ev_if.event_valid), 32'h0);
    end

    // Basic change: led must move on the sixth edge after first sampling.
    sw = 8'hFF;
    step(6);
    chk("basic_led_early", 32'(led), 32'h00);
    chk("basic_valid_early", 32'(ev_if.event_valid), 32'h0);
    step(1);
    chk("basic_led", 32'(led), 32'hFF);
    chk("basic_valid", 32'(ev_if.event_valid), 32'h1);
    chk("basic_data", 32'(ev_if.event_data), 32'hFF);
    chk("basic_mask", 32'(ev_if.event_mask), 32'hFF);
    ev_if.event_ready = 1'b1;
    step(1);
    ev_if.event_ready = 1'b0;
    chk("basic_accept_valid", 32'(ev_if.event_valid), 32'h0);
    chk("basic_accept_ovr", 32'(overrun), 32'h0);

    for (int i = 0; i < 7; i++) begin
      sw = vecs[i].sw;
      ev_if.event_ready = vecs[i].rdy;
      step(vecs[i].cycles);
      chk($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].led));
      chk($sformatf("vec%0d_valid", i), 32'(ev_if.event_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_data", i), 32'(ev_if.event_data), 32'(vecs[i].data));
      chk($sformatf("vec%0d_mask", i), 32'(ev_if.event_mask), 32'(vecs[i].mask));
      chk($sformatf("vec%0d_ovr", i), 32'(overrun), 32'(vecs[i].ovr));
    end
    ev_if.event_ready = 1'b0;

    // Asynchronous reset mid-count with an event pending and overrun set.
    sw = 8'hA5;
    step(10);
    chk("pre_rst_valid", 32'(ev_if.event_valid), 32'h1);
    sw = 8'h5A;
    step(4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_led", 32'(led), 32'h00);
    chk("arst_valid", 32'(ev_if.event_valid), 32'h0);
    chk("arst_data", 32'(ev_if.event_data), 32'h00);
    chk("arst_mask", 32'(ev_if.event_mask), 32'h00);
    chk("arst_ovr", 32'(overrun), 32'h0);
    sw = 8'h00;
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("post_rst_idle", 32'({led, ev_if.event_valid}), 32'h0);
    end

    // Bounce on bit0 from a settled FE.
    sw = 8'hFE;
    ev_if.event_ready = 1'b1;
    step(12);
    ev_if.event_ready = 1'b0;
    chk("bounce_pre_led", 32'(led), 32'hFE);
    chk("bounce_pre_valid", 32'(ev_if.event_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      sw = (i % 2 == 0) ? 8'hFF : 8'hFE;
      for (int j = 0; j < 2; j++) begin
        step(1);
        chk("bounce_hold", 32'({led, ev_if.event_valid}), 32'h1FC);
      end
    end
    sw = 8'hFF;
    step(12);
    chk("bounce_led", 32'(led), 32'hFF);
    chk("bounce_valid", 32'(ev_if.event_valid), 32'h1);
    chk("bounce_data", 32'(ev_if.event_data), 32'hFF);
    chk("bounce_mask", 32'(ev_if.event_mask), 32'h01);
    chk("bounce_ovr", 32'(overrun), 32'h0);
    ev_if.event_ready = 1'b1;
    step(1);
    ev_if.event_ready = 1'b0;

    // Short pulse on bit7 must be filtered out.
    sw = 8'h7F;
    step(3);
    sw = 8'hFF;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("pulse_hold", 32'({led, ev_if.event_valid}), 32'h1FE);
    end

    // Accept on the exact edge a new value qualifies.
    sw = 8'h30;
    step(12);
    chk("coinc_pre_valid", 32'(ev_if.event_valid), 32'h1);
    chk("coinc_pre_mask", 32'(ev_if.event_mask), 32'hCF);
    sw = 8'h33;
    step(6);
    chk("coinc_led_early", 32'(led), 32'h30);
    ev_if.event_ready = 1'b1;
    step(1);
    ev_if.event_ready = 1'b0;
    chk("coinc_led", 32'(led), 32'h33);
    chk("coinc_valid", 32'(ev_if.event_valid), 32'h1);
    chk("coinc_data", 32'(ev_if.event_data), 32'h33);
    chk("coinc_mask", 32'(ev_if.event_mask), 32'h03);
    chk("coinc_ovr", 32'(overrun), 32'h0);

    // Soak: each value held STABLE_CYCLES+4 edges; led changes on hold edge 6.
    m_led = 8'h33; m_valid = 1'b1; m_data = 8'h33; m_mask = 8'h03; m_ovr = 1'b0;
    for (int k = 0; k < 100; k++) begin
      sw = 8'($random);
      for (int i = 0; i < STABLE_CYCLES + 4; i++) begin
        ev_if.event_ready = 1'($urandom_range(0, 1));
        step(1);
        if (i == STABLE_CYCLES + 2 && sw != m_led) begin
          if (!m_valid || ev_if.event_ready) begin
            m_mask = m_led ^ sw;
          end else begin
            m_mask = m_mask | (m_led ^ sw);
            m_ovr  = 1'b1;
          end
          m_data  = sw;
          m_valid = 1'b1;
          m_led   = sw;
        end else if (m_valid && ev_if.event_ready) begin
          m_valid = 1'b0;
        end
        chk("soak", 32'({led, ev_if.event_valid, ev_if.event_data, ev_if.event_mask, overrun}),
            32'({m_led, m_valid, m_data, m_mask, m_ovr}));
      end
    end
    ev_if.event_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debounce_reader.md
Name: switch_debounce_reader

Overview:
Reads the 8-bit user switch bank as an asynchronous input: synchronizes it, debounces it per bank, and drives the LEDs from the debounced state. Each debounced change is reported to downstream logic as an event (new value plus changed-bit mask) through a valid/ready handshake. Sits between the board switches and any control logic that consumes switch settings.

Parameters:
WIDTH, 8, number of switches/LEDs.
STABLE_CYCLES, 4, consecutive identical synchronized samples required before a new value is accepted (legal range 1..65535).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
switch  input  WIDTH  raw switch levels, asynchronous to clk.
led  output  WIDTH  debounced switch state.
event_valid  output  1  a debounced change is pending.
event_ready  input  1  consumer accepts the pending event.
event_data  output  WIDTH  debounced value of the pending event.
event_mask  output  WIDTH  bits changed since the last accepted event (1 = changed).
overrun  output  1  sticky: a change arrived while an event was pending and unaccepted.

Behaviour:
- Reset (asynchronous, immediate, including mid-count and with an event pending): sync stages, candidate, counter, led, event_data, event_mask = 0; event_valid = 0; overrun = 0.
- Synchronizer: two flops per bit. sw_s1 <= switch; sw_s2 <= sw_s1. No logic between the stages.
- Debounce is whole-vector, using a candidate register cand and counter cnt (16 bits, saturating at STABLE_CYCLES-1).
- If sw_s2 != cand: cand <= sw_s2, cnt <= 0.
- Else if cnt == STABLE_CYCLES-1 and cand != led: led <= cand, and a change is raised this edge.
- Else if cnt < STABLE_CYCLES-1: cnt <= cnt+1.
- Latency: a switch value first sampled at edge E0 and held appears on led after edge E0+STABLE_CYCLES+2. This is 6 edges for the default.
- Glitches: any sw_s2 change restarts the count. A pulse that returns to the current led value before qualifying produces no led change and no event.
- Event raised with event_valid=0, or with event_valid=1 and event_ready=1 on the same edge: event_data <= new led, event_mask <= old led ^ new led, event_valid <= 1. overrun is unchanged.
- Event raised with event_valid=1 and event_ready=0: event_data <= new led; event_mask <= event_mask | (old ^ new); overrun <= 1; valid stays 1.
- event_valid=1, event_ready=1, no new event: event_valid <= 0. event_data and event_mask hold their last values.
- event_ready while event_valid=0 is ignored.
- event_data, event_mask and event_valid are stable while valid && !ready.
- overrun clears only on rst.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- Reset: assert rst with switch=8'hA5 mid-operation -> led, event_valid, event_mask and overrun read 0 immediately with no clock edge. After release with switch=8'h00: no event for 20 cycles.
- Basic change: switch=8'hFF from edge E0, event_ready=0 -> led=8'hFF after edge E0+6, not before. event_valid=1, event_data=8'hFF, event_mask=8'hFF. One cycle of event_ready=1 -> event_valid=0, overrun=0.
- Bounce: bit0 toggles 1,0,1,0,1 with 2-cycle dwell, then holds 1 -> exactly one event, data=8'hFF and mask=8'h01 from a prior 8'hFE. A separate 3-cycle pulse on bit7 that returns to its original value -> no led change, no event.
- Overrun: event_ready=0; switch 8'h00 -> 8'hCD (settle) -> 8'h0F (settle) -> event_data=8'h0F, event_mask=8'hCD|8'hC2=8'hCF, overrun=1. After accept, overrun stays 1 until rst.
- Coincident accept and new event: event_ready=1 on the exact edge a new led value 8'h33 qualifies (previous led 8'h30) -> event_valid stays 1, event_data=8'h33, event_mask=8'h03, overrun=0.
- Soak: 100 $random switch values, each held STABLE_CYCLES+4 cycles, event_ready random -> scoreboard checks led against the settled value, event_data against the last led, and event_mask against the OR of diffs since the last accept.
